store_buffer: RTL

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer_pkg.sv | 12 +
 rtl/sb_match.sv | 34 +++
 rtl/store_buffer.sv | 118 +++++++++++
 3 files changed

// File: rtl/store_buffer_pkg.sv
// Shared sizing defaults for the store buffer and its address-match helper.
package store_buffer_pkg;
  localparam int SB_W     = 16;
  localparam int SB_DEPTH = 4;

  // Count must hold 0..DEPTH inclusive, so one bit wider than a pointer.
  function automatic int sb_cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int SB_CNT_W = sb_cnt_width(SB_DEPTH);
endpackage

// File: rtl/sb_match.sv
// Combinational store-to-load forwarding: youngest valid entry whose address matches wins.
module sb_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int W     = SB_W
) (
  input  logic [DEPTH*W-1:0]                i_addr_flat,
  input  logic [DEPTH*W-1:0]                i_data_flat,
  input  logic [$clog2(DEPTH)-1:0]          i_head,
  input  logic [sb_cnt_width(DEPTH)-1:0]    i_count,
  input  logic [W-1:0]                      i_load_addr,
  output logic                              o_hit,
  output logic [W-1:0]                      o_data
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = sb_cnt_width(DEPTH);

  logic [PW-1:0] w_idx;

  // Walk oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    w_idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = i_head + PW'(k);
      if ((CW'(k) < i_count) && (i_addr_flat[w_idx*W +: W] == i_load_addr)) begin
        o_hit  = 1'b1;
        o_data = i_data_flat[w_idx*W +: W];
      end
    end
  end
endmodule

// File: rtl/store_buffer.sv
// FIFO store buffer between the CPU MEM stage and data memory, with load forwarding
// and background draining whenever the request port is idle.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int W     = SB_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  input  logic         req_write,
  input  logic [W-1:0] req_addr,
  input  logic [W-1:0] req_wdata,
  output logic         req_ready,
  output logic         resp_valid,
  output logic [W-1:0] resp_rdata,
  output logic [W-1:0] MemAddr,
  output logic [W-1:0] WriteData,
  output logic         MemWrite,
  output logic         MemRead,
  input  logic [W-1:0] ReadData,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = sb_cnt_width(DEPTH);

  logic [W-1:0]       r_addr_mem [DEPTH];
  logic [W-1:0]       r_data_mem [DEPTH];
  logic [PW-1:0]      r_head;
  logic [PW-1:0]      r_tail;
  logic [CW-1:0]      r_count;
  logic               r_resp_valid;
  logic [W-1:0]       r_resp_rdata;

  logic               w_full;
  logic               w_empty;
  logic               w_accept;
  logic               w_store;
  logic               w_load;
  logic               w_drain;
  logic               w_hit;
  logic [W-1:0]       w_hit_data;
  logic [DEPTH*W-1:0] w_addr_flat;
  logic [DEPTH*W-1:0] w_data_flat;

  assign w_full     = (r_count == CW'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign full       = w_full;
  assign empty      = w_empty;
  assign req_ready  = !w_full && !reset;
  assign w_accept   = req_valid && req_ready;
  assign w_store    = w_accept && req_write;
  assign w_load     = w_accept && !req_write;
  // Memory port is shared: draining only happens on cycles the CPU leaves free.
  assign w_drain    = !w_empty && !w_accept && !reset;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_flat
      assign w_addr_flat[gi*W +: W] = r_addr_mem[gi];
      assign w_data_flat[gi*W +: W] = r_data_mem[gi];
    end
  endgenerate

  sb_match #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_match (
    .i_addr_flat (w_addr_flat),
    .i_data_flat (w_data_flat),
    .i_head      (r_head),
    .i_count     (r_count),
    .i_load_addr (req_addr),
    .o_hit       (w_hit),
    .o_data      (w_hit_data)
  );

  always_ff @(posedge clk) begin
    if (w_store) begin
      r_addr_mem[r_tail] <= req_addr;
      r_data_mem[r_tail] <= req_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      if (w_store) r_tail <= r_tail + PW'(1);
      if (w_drain) r_head <= r_head + PW'(1);
      r_count      <= r_count + CW'(w_store) - CW'(w_drain);
      r_resp_valid <= w_load;
      if (w_load) r_resp_rdata <= w_hit ? w_hit_data : ReadData;
    end
  end

  always_comb begin
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    MemAddr   = '0;
    WriteData = '0;
    if (w_load && !w_hit) begin
      MemRead = 1'b1;
      MemAddr = req_addr;
    end else if (w_drain) begin
      MemWrite  = 1'b1;
      MemAddr   = r_addr_mem[r_head];
      WriteData = r_data_mem[r_head];
    end
  end
endmodule
